gate_scheduler: RTL



---
 rtl/gate_scheduler.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/gate_scheduler.sv
// Round-robin scheduler sharing one trigger-gate generator among NREQ pulse requesters.
// Optional drop counter enabled by defining GATE_SCHED_DROP_CNT_EN.
module gate_scheduler #(
    parameter int NREQ = 4,
    parameter int WW   = 8,
    parameter int HW   = 8,
    parameter int OW   = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            enable_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [WW-1:0]   width_i,
    input  logic [HW-1:0]   holdoff_i,
    output logic            gate_o,
    output logic [NREQ-1:0] grant_o,
    output logic [OW-1:0]   owner_o,
    output logic            busy_o,
    output logic [NREQ-1:0] pend_o,
    output logic [15:0]     drop_cnt_o,
    input  logic            drop_clr_i
);

    localparam int CW = (WW > HW) ? WW : HW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              gate_q, gate_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   pend_q, pend_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [HW-1:0]     hold_q, hold_d;

    logic              found_s;
    logic [OW-1:0]     winner_s;
    logic              grant_edge_s;
    logic [NREQ-1:0]   clr_mask_s;
    logic [CW-1:0]     load_width_s;

    function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int step);
        int sum_v;
        sum_v = int'(base) + step;
        sum_v = (sum_v >= NREQ) ? (sum_v - NREQ) : sum_v;
        return OW'(sum_v);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
        logic [NREQ-1:0] oh_v;
        oh_v = {NREQ{1'b0}};
        oh_v[idx] = 1'b1;
        return oh_v;
    endfunction

    // Round-robin scan starting just above the previous owner, wrapping modulo NREQ.
    always_comb begin
        found_s  = 1'b0;
        winner_s = owner_q;
        for (int i = 1; i <= NREQ; i++) begin
            winner_s = (!found_s && pend_q[wrap_idx(owner_q, i)]) ? wrap_idx(owner_q, i) : winner_s;
            found_s  = found_s | pend_q[wrap_idx(owner_q, i)];
        end
    end

    assign grant_edge_s = (state_q == ST_IDLE) && enable_i && found_s;
    assign clr_mask_s   = grant_edge_s ? onehot(winner_s) : {NREQ{1'b0}};
    assign load_width_s = (width_i == {WW{1'b0}}) ? CW'(1'b1) : CW'(width_i);

    // Pending latch: a fresh pulse beats the grant clear; disabling flushes everything.
    always_comb begin
        pend_d = pend_q;
        if (enable_i) begin
            pend_d = (pend_q & ~clr_mask_s) | req_i;
        end else begin
            pend_d = {NREQ{1'b0}};
        end
    end

    // Gate / holdoff sequencing.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        grant_d = grant_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_edge_s) begin
                    state_d = ST_GATE;
                    gate_d  = 1'b1;
                    grant_d = onehot(winner_s);
                    owner_d = winner_s;
                    busy_d  = 1'b1;
                    cnt_d   = load_width_s;
                    hold_d  = holdoff_i;
                end else begin
                    gate_d  = 1'b0;
                    grant_d = {NREQ{1'b0}};
                    busy_d  = 1'b0;
                end
            end
            ST_GATE: begin
                if (cnt_q == CW'(1'b1)) begin
                    gate_d  = 1'b0;
                    grant_d = {NREQ{1'b0}};
                    if (hold_q != {HW{1'b0}}) begin
                        state_d = ST_HOLD;
                        cnt_d   = CW'(hold_q);
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        cnt_d   = {CW{1'b0}};
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1'b1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(1'b1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q - CW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gate_d  = 1'b0;
                grant_d = {NREQ{1'b0}};
                busy_d  = 1'b0;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers; owner resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            gate_q  <= 1'b0;
            grant_q <= {NREQ{1'b0}};
            owner_q <= OW'(NREQ - 1);
            busy_q  <= 1'b0;
            pend_q  <= {NREQ{1'b0}};
            cnt_q   <= {CW{1'b0}};
            hold_q  <= {HW{1'b0}};
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    assign gate_o  = gate_q;
    assign grant_o = grant_q;
    assign owner_o = owner_q;
    assign busy_o  = busy_q;
    assign pend_o  = pend_q;

`ifdef GATE_SCHED_DROP_CNT_EN
    logic [NREQ-1:0] drops_s;
    logic [16:0]     drop_sum_s;
    logic [15:0]     drop_q, drop_d;

    function automatic logic [4:0] popcount(input logic [NREQ-1:0] v);
        logic [4:0] c_v;
        c_v = 5'd0;
        for (int i = 0; i < NREQ; i++) begin
            c_v = c_v + {4'd0, v[i]};
        end
        return c_v;
    endfunction

    // A drop is a pulse onto an already-pending flag that is not cleared this edge.
    assign drops_s    = enable_i ? (req_i & pend_q & ~clr_mask_s) : {NREQ{1'b0}};
    assign drop_sum_s = {1'b0, drop_q} + {12'd0, popcount(drops_s)};

    // Saturating accumulate; clear has priority over same-edge drops.
    always_comb begin
        drop_d = drop_q;
        if (drop_clr_i) begin
            drop_d = 16'h0000;
        end else begin
            drop_d = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drop_q <= 16'h0000;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt_o = drop_q;
`else
    logic drop_clr_unused_s;
    assign drop_clr_unused_s = drop_clr_i;
    assign drop_cnt_o        = 16'h0000;
`endif

endmodule
